apb_dac_adc_regs: RTL and testbench
===================================

Name: apb_dac_adc_regs

Overview:
- APB3 completer (responder) for the HPMS FIC_2_APB master port. It gives the Cortex-M3 firmware register access to the DAC/ADC datapath.
- It holds the control and status registers, an 8-deep DAC sample FIFO that drains to a valid/ready stream, an ADC sample capture register and an interrupt line.
- Placed in the fabric next to the system builder. Clocked from FAB_CCC_GL0 and reset from the fabric reset tree.

Parameters:
- DW, 12, DAC/ADC sample width (1..16).
- FIFO_DEPTH, 8, DAC FIFO depth (power of 2, 2..64).
- WAIT_STATES, 1, PREADY-low cycles inserted in each access phase (0..7).

Ports:
- PCLK  in  1  bus/core clock (FAB_CCC_GL0).
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write.
- PADDR  in  6  word address [7:2].
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid with PREADY.
- DAC_DATA  out  DW  FIFO head sample.
- DAC_VALID  out  1  sample available.
- DAC_READY  in  1  DAC consumer accepts.
- ADC_DATA  in  DW  ADC sample.
- ADC_VALID  in  1  one-cycle sample strobe.
- IRQ  out  1  level interrupt to HPMS (MSS_INT_F2M).

Behaviour:
- Reset (asynchronous, PRESET=1): all registers clear. PRDATA=0, PREADY=0, PSLVERR=0, DAC_VALID=0, IRQ=0, FIFO empty.
- Bus FSM states IDLE, WAIT, RESP.
  - IDLE -> WAIT on PSEL & !PENABLE (setup phase); the wait counter loads WAIT_STATES.
  - WAIT: PREADY=0; the counter decrements each access-phase cycle. At 0, go to RESP.
  - RESP: PREADY=1 for exactly one cycle with PENABLE high, then return to IDLE.
  - Latency with WAIT_STATES=0 is one access cycle. Otherwise it is WAIT_STATES+1.
- If PSEL drops while in WAIT or RESP (protocol violation), return to IDLE with no side effects.
- Register side effects and the PRDATA/PSLVERR update happen only in the RESP cycle. PRDATA is 0 on writes and errors.
- Register map (byte offset):
  - 0x00 CTRL RW: [0] DAC_EN, [1] ADC_EN, [2] IRQ_EN, [3] FIFO_CLR (write-1 pulse, reads 0).
  - 0x04 STATUS RO: [0] fifo_empty, [1] fifo_full, [2] adc_valid, [3] adc_overrun (sticky), [14:8] fifo_level.
  - 0x08 DAC_WR WO: pushes PWDATA[DW-1:0]. If the FIFO is full: PSLVERR=1 and the sample is dropped.
  - 0x0C ADC_RD RO: last captured sample, zero-extended. Reading clears adc_valid and adc_overrun.
  - 0x10 IRQ_STAT W1C: [0] adc_sample, [1] fifo_empty_edge.
  - Writes to RO registers, reads of 0x08, and all unmapped offsets: PSLVERR=1 and no state change.
- DAC stream:
  - DAC_VALID = DAC_EN & !fifo_empty. DAC_DATA = FIFO head.
  - Pop on DAC_VALID & DAC_READY.
  - A simultaneous push and pop on a full FIFO: the push is still rejected (full is evaluated before the pop).
  - A simultaneous push and pop on an empty FIFO: the push is accepted and no pop occurs.
  - FIFO_CLR empties the FIFO the same cycle; a push in that cycle is discarded.
- ADC capture:
  - On ADC_VALID & ADC_EN: latch ADC_DATA, set adc_valid, set IRQ_STAT[0]. If adc_valid was already set, also set adc_overrun.
  - ADC_RD read in the same cycle as ADC_VALID: the new sample is captured, adc_valid stays 1 and no overrun is flagged. The returned PRDATA is the old sample.
- IRQ_STAT[1] sets on the cycle the FIFO goes from non-empty to empty.
- IRQ = IRQ_EN & |IRQ_STAT, registered. A W1C write in the same cycle as a set event leaves the bit set.
- Reset mid-transfer aborts the transfer: FSM to IDLE, and the partial write has no effect.

Decomposition:
- Package apb_dac_adc_pkg holds the register offset constants, the CTRL/STATUS/IRQ bit-index constants and the bus FSM state enum.
- Sub-module: dac_sync_fifo, a single-clock FIFO of width DW and depth FIFO_DEPTH with push, pop, clr, full, empty and level outputs.
- Bus FSM and register decode stay in the top level.

Test Plan:
- Reset, then read STATUS with WAIT_STATES=1 -> PREADY low for 1 access cycle then high; PRDATA=0x00000001; PSLVERR=0.
- Write CTRL=0x1, hold DAC_READY=0, write DAC_WR 0x123 nine times -> first 8 OKAY, 9th PSLVERR=1; STATUS=0x00000802; raise DAC_READY -> DAC_DATA outputs 0x123 for 8 consecutive cycles, then DAC_VALID=0.
- With CTRL=0x6, drive ADC_VALID twice with 0x0AB then 0x0CD before any read -> STATUS[3:2]=2'b11; IRQ=1; read ADC_RD returns 0x000000CD and clears both bits; write IRQ_STAT=0x1 -> IRQ=0.
- ADC_VALID (0x055) in the same cycle as the RESP of an ADC_RD read holding 0x044 -> PRDATA=0x44; STATUS afterwards shows adc_valid=1 and adc_overrun=0.
- Access offset 0x1C and write to STATUS -> PSLVERR=1, PRDATA=0, CTRL/STATUS unchanged.
- Assert PRESET during the WAIT state of a DAC_WR -> PREADY=0 immediately; after release, STATUS=0x00000001 (FIFO empty).

Source files
------------

// File: rtl/apb_dac_adc_pkg.sv
// ---------------------------------------------------------------------------
// apb_dac_adc_pkg
// Shared constants for the APB DAC/ADC register block:
//   - word addresses (PADDR[7:2]) of every mapped register
//   - bit positions inside CTRL, STATUS and IRQ_STAT
//   - the APB completer state encoding
// No ports; imported by apb_dac_adc_regs and dac_sync_fifo.
// ---------------------------------------------------------------------------
package apb_dac_adc_pkg;

    // Word addresses, i.e. byte offset >> 2
    localparam logic [5:0] ADDR_CTRL     = 6'h00;  // 0x00
    localparam logic [5:0] ADDR_STATUS   = 6'h01;  // 0x04
    localparam logic [5:0] ADDR_DAC_WR   = 6'h02;  // 0x08
    localparam logic [5:0] ADDR_ADC_RD   = 6'h03;  // 0x0C
    localparam logic [5:0] ADDR_IRQ_STAT = 6'h04;  // 0x10

    // CTRL bits
    localparam int CTRL_DAC_EN   = 0;
    localparam int CTRL_ADC_EN   = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_FIFO_CLR = 3;

    // STATUS bits
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_ADC_VALID = 2;
    localparam int STAT_ADC_OVR   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    // IRQ_STAT bits
    localparam int IRQ_ADC_SAMPLE = 0;
    localparam int IRQ_FIFO_EMPTY = 1;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/dac_sync_fifo.sv
// ---------------------------------------------------------------------------
// dac_sync_fifo
// Single-clock FIFO holding DAC samples on their way to the DAC stream.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, wdata   write request and sample; ignored while full
//   pop           read request; ignored while empty
//   clr           empties the FIFO; overrides push and pop in the same cycle
//   rdata         sample at the head of the FIFO
//   full, empty   occupancy flags (from current state, before this cycle's ops)
//   level         number of stored samples, 0..DEPTH
// ---------------------------------------------------------------------------
module dac_sync_fifo
    import apb_dac_adc_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    input  logic          clr,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    // Flags come from the registered level, so a push into a full FIFO is
    // refused even when a pop frees a slot in the same cycle.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state: clear wins over everything; pointers wrap naturally since
    // DEPTH is a power of two.
    always_comb begin
        push_ok  = push && !full && !clr;
        pop_ok   = pop && !empty && !clr;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/apb_dac_adc_regs.sv
// ---------------------------------------------------------------------------
// apb_dac_adc_regs
// APB3 completer giving firmware access to the DAC/ADC datapath: control and
// status registers, DAC sample FIFO drained as a valid/ready stream, ADC
// capture register and a level interrupt.
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   PSEL..PWDATA                 APB3 request
//   PRDATA, PREADY, PSLVERR      APB3 response (valid while PREADY=1)
//   DAC_DATA, DAC_VALID, DAC_READY  DAC sample stream (FIFO head)
//   ADC_DATA, ADC_VALID          ADC sample and one-cycle strobe
//   IRQ                          registered level interrupt
// ---------------------------------------------------------------------------
module apb_dac_adc_regs
    import apb_dac_adc_pkg::*;
#(
    parameter int DW          = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [5:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic [DW-1:0] DAC_DATA,
    output logic          DAC_VALID,
    input  logic          DAC_READY,
    input  logic [DW-1:0] ADC_DATA,
    input  logic          ADC_VALID,
    output logic          IRQ
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;

    bus_state_e    state_q, state_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] adc_data_q, adc_data_d;
    logic          adc_valid_q, adc_valid_d;
    logic          adc_ovr_q, adc_ovr_d;
    logic [1:0]    irq_stat_q, irq_stat_d;
    logic          irq_q, irq_d;

    logic          resp;
    logic          access;
    logic          bus_err;
    logic [31:0]   rd_data;
    logic [31:0]   status;
    logic          wr_ctrl;
    logic          wr_irq;
    logic          rd_adc;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          going_empty;
    logic          adc_capture;
    logic [1:0]    irq_set;
    logic [1:0]    irq_clr;
    logic          unused_pwdata;

    // Bus FSM next state. With no wait states the setup phase jumps straight
    // to RESP so the first access cycle completes; otherwise WAIT counts the
    // access cycles down and hands over to RESP when the count runs out.
    // Losing PSEL mid-transfer drops back to IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            BUS_IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        state_d = BUS_RESP;
                    end else begin
                        state_d    = BUS_WAIT;
                        wait_cnt_d = 3'(WAIT_STATES);
                    end
                end
            end
            BUS_WAIT: begin
                if (!PSEL) begin
                    state_d = BUS_IDLE;
                end else if (PENABLE) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                    if (wait_cnt_q == 3'd1) begin
                        state_d = BUS_RESP;
                    end
                end
            end
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // FIFO instance; pops are blocked by DAC_EN through DAC_VALID
    dac_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (fifo_push),
        .wdata (PWDATA[DW-1:0]),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .rdata (DAC_DATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign DAC_VALID = ctrl_q[CTRL_DAC_EN] && !fifo_empty;
    assign fifo_pop  = DAC_VALID && DAC_READY;

    // STATUS word assembled from live flags
    always_comb begin
        status                            = '0;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_FULL]                 = fifo_full;
        status[STAT_ADC_VALID]            = adc_valid_q;
        status[STAT_ADC_OVR]              = adc_ovr_q;
        status[STAT_LEVEL_LSB +: LW]      = fifo_level;
    end

    // Address decode: read data and error for the current request. A push
    // into a full FIFO is reported as an error and the sample is dropped.
    always_comb begin
        rd_data = '0;
        bus_err = 1'b0;
        case (PADDR)
            ADDR_CTRL:     rd_data = {29'd0, ctrl_q};
            ADDR_STATUS: begin
                if (PWRITE) bus_err = 1'b1;
                else        rd_data = status;
            end
            ADDR_DAC_WR: begin
                if (!PWRITE || fifo_full) bus_err = 1'b1;
            end
            ADDR_ADC_RD: begin
                if (PWRITE) bus_err = 1'b1;
                else        rd_data = {{(32-DW){1'b0}}, adc_data_q};
            end
            ADDR_IRQ_STAT: rd_data = {30'd0, irq_stat_q};
            default:       bus_err = 1'b1;
        endcase
    end

    // Response outputs only exist in RESP; the completing edge at the end of
    // RESP is the one that commits register side effects.
    assign resp    = (state_q == BUS_RESP);
    assign access  = resp && PSEL && PENABLE && !bus_err;
    assign PREADY  = resp;
    assign PSLVERR = resp && bus_err;
    assign PRDATA  = (resp && !bus_err && !PWRITE) ? rd_data : 32'd0;

    assign wr_ctrl   = access && PWRITE && (PADDR == ADDR_CTRL);
    assign wr_irq    = access && PWRITE && (PADDR == ADDR_IRQ_STAT);
    assign rd_adc    = access && !PWRITE && (PADDR == ADDR_ADC_RD);
    assign fifo_push = access && PWRITE && (PADDR == ADDR_DAC_WR);
    assign fifo_clr  = wr_ctrl && PWDATA[CTRL_FIFO_CLR];

    assign unused_pwdata = ^PWDATA;

    // Detect the edge into empty on the same cycle the FIFO state changes:
    // either a clear of a non-empty FIFO or popping the last sample without
    // a refill.
    assign going_empty = !fifo_empty &&
                         (fifo_clr || (fifo_pop && !fifo_push && (fifo_level == LW'(1))));

    // Register next state. A read of ADC_RD coinciding with a new sample
    // leaves adc_valid set and never flags overrun; W1C loses to a set in
    // the same cycle.
    always_comb begin
        adc_capture = ADC_VALID && ctrl_q[CTRL_ADC_EN];

        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = PWDATA[2:0];
        end

        adc_data_d = adc_capture ? ADC_DATA : adc_data_q;

        adc_valid_d = adc_valid_q;
        if (rd_adc)      adc_valid_d = 1'b0;
        if (adc_capture) adc_valid_d = 1'b1;

        adc_ovr_d = adc_ovr_q;
        if (adc_capture && adc_valid_q) adc_ovr_d = 1'b1;
        if (rd_adc)                     adc_ovr_d = 1'b0;

        irq_set                 = '0;
        irq_set[IRQ_ADC_SAMPLE] = adc_capture;
        irq_set[IRQ_FIFO_EMPTY] = going_empty;
        irq_clr                 = wr_irq ? PWDATA[1:0] : 2'b00;
        irq_stat_d              = (irq_stat_q & ~irq_clr) | irq_set;

        irq_d = ctrl_q[CTRL_IRQ_EN] && (|irq_stat_q);
    end

    // State registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= BUS_IDLE;
            wait_cnt_q  <= '0;
            ctrl_q      <= '0;
            adc_data_q  <= '0;
            adc_valid_q <= 1'b0;
            adc_ovr_q   <= 1'b0;
            irq_stat_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ctrl_q      <= ctrl_d;
            adc_data_q  <= adc_data_d;
            adc_valid_q <= adc_valid_d;
            adc_ovr_q   <= adc_ovr_d;
            irq_stat_q  <= irq_stat_d;
            irq_q       <= irq_d;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_apb_dac_adc_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_dac_adc_regs
// Self-checking bench for apb_dac_adc_regs. A behavioural model (queue for the
// FIFO, plain variables for the registers) predicts every bus response, the
// DAC stream and IRQ; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_apb_dac_adc_regs;

   localparam int DW    = 12;
   localparam int DEPTH = 8;
   localparam int WS    = 1;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [5:0]    PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic [DW-1:0] DAC_DATA;
   logic          DAC_VALID;
   logic          DAC_READY;
   logic [DW-1:0] ADC_DATA;
   logic          ADC_VALID;
   logic          IRQ;

   int testCount = 0;
   int failCount = 0;

   // Reference model state
   logic [2:0]    mCtrl;
   logic [DW-1:0] mFifo[$];
   logic [DW-1:0] mAdcData;
   bit            mAdcValid;
   bit            mAdcOvr;
   logic [1:0]    mIrqStat;

   apb_dac_adc_regs #(
      .DW          (DW),
      .FIFO_DEPTH  (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .DAC_DATA  (DAC_DATA),
      .DAC_VALID (DAC_VALID),
      .DAC_READY (DAC_READY),
      .ADC_DATA  (ADC_DATA),
      .ADC_VALID (ADC_VALID),
      .IRQ       (IRQ)
   );

   // Clock
   always #5 PCLK = ~PCLK;

   // Safety net so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic void resetModel();
      mCtrl     = '0;
      mFifo.delete();
      mAdcData  = '0;
      mAdcValid = 0;
      mAdcOvr   = 0;
      mIrqStat  = '0;
   endfunction

   function automatic logic [31:0] statusWord();
      logic [31:0] s;
      s = 32'(mFifo.size()) << 8;
      s[3] = mAdcOvr;
      s[2] = mAdcValid;
      s[1] = (mFifo.size() == DEPTH);
      s[0] = (mFifo.size() == 0);
      return s;
   endfunction

   // Register-map behaviour as seen by firmware
   function automatic void modelAccess(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                                       output logic [31:0] rdata, output bit err);
      rdata = '0;
      err   = 0;
      case (addr)
         6'h00: begin
            if (wr) begin
               mCtrl = data[2:0];
               if (data[3]) begin
                  if (mFifo.size() != 0) mIrqStat[1] = 1'b1;
                  mFifo.delete();
               end
            end else rdata = {29'd0, mCtrl};
         end
         6'h01: if (wr) err = 1; else rdata = statusWord();
         6'h02: begin
            if (!wr || mFifo.size() == DEPTH) err = 1;
            else mFifo.push_back(data[DW-1:0]);
         end
         6'h03: begin
            if (wr) err = 1;
            else begin
               rdata     = 32'(mAdcData);
               mAdcValid = 0;
               mAdcOvr   = 0;
            end
         end
         6'h04: if (wr) mIrqStat = mIrqStat & ~data[1:0]; else rdata = {30'd0, mIrqStat};
         default: err = 1;
      endcase
   endfunction

   function automatic void modelAdc(input logic [DW-1:0] v);
      if (mCtrl[1]) begin
         if (mAdcValid) mAdcOvr = 1;
         mAdcValid   = 1;
         mAdcData    = v;
         mIrqStat[0] = 1'b1;
      end
   endfunction

   // One APB transfer; optionally strobes ADC_VALID so it lands on the
   // completing edge of the transfer.
   task automatic applyStimulus(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                                input bit adcInResp, input logic [DW-1:0] adcVal,
                                output logic [31:0] rdata, output logic err, output int waits);
      bit done;
      waits = 0;
      rdata = '0;
      err   = 1'b0;
      done  = 0;
      @(posedge PCLK); #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge PCLK);
         if (PREADY) begin
            done  = 1;
            rdata = PRDATA;
            err   = PSLVERR;
            if (adcInResp) begin
               ADC_VALID = 1'b1;
               ADC_DATA  = adcVal;
            end
         end else begin
            waits++;
         end
      end
      if (!done) checkOutput("pready_timeout", 32'd0, 32'd1);
      @(posedge PCLK); #1;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      ADC_VALID = 1'b0;
   endtask

   task automatic doAccess(input string tag, input bit wr, input logic [5:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      logic [31:0] expRd;
      logic        err;
      bit          expErr;
      int          waits;
      applyStimulus(wr, addr, data, 1'b0, '0, rd, err, waits);
      modelAccess(wr, addr, data, expRd, expErr);
      checkOutput({tag, "_prdata"}, rd, expRd);
      checkOutput({tag, "_pslverr"}, 32'(err), 32'(expErr));
      checkOutput({tag, "_waits"}, waits, WS);
   endtask

   task automatic adcPulse(input logic [DW-1:0] v);
      @(posedge PCLK); #1;
      ADC_VALID = 1'b1;
      ADC_DATA  = v;
      @(posedge PCLK); #1;
      ADC_VALID = 1'b0;
      modelAdc(v);
   endtask

   // Holds DAC_READY for n cycles and follows the stream sample by sample
   task automatic drain(input int n);
      bit expValid;
      @(posedge PCLK); #1;
      DAC_READY = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge PCLK);
         expValid = mCtrl[0] && (mFifo.size() > 0);
         checkOutput("dac_valid", 32'(DAC_VALID), 32'(expValid));
         if (expValid) begin
            checkOutput("dac_data", 32'(DAC_DATA), 32'(mFifo[0]));
            void'(mFifo.pop_front());
            if (mFifo.size() == 0) mIrqStat[1] = 1'b1;
         end
         @(posedge PCLK); #1;
      end
      DAC_READY = 1'b0;
   endtask

   task automatic checkIrq(input string tag);
      @(posedge PCLK); #1;
      checkOutput(tag, 32'(IRQ), 32'(mCtrl[2] && (|mIrqStat)));
   endtask

   task automatic doReset();
      PRESET    = 1'b1;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      PWRITE    = 1'b0;
      PADDR     = '0;
      PWDATA    = '0;
      DAC_READY = 1'b0;
      ADC_DATA  = '0;
      ADC_VALID = 1'b0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      resetModel();
   endtask

   task automatic randomOp();
      int op;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      case (op)
         0: begin
            d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d[3] = 1'b1;
            doAccess("rnd_ctrl_wr", 1, 6'h00, d);
         end
         1, 2: doAccess("rnd_dac_wr", 1, 6'h02, $urandom);
         3: doAccess("rnd_status", 0, 6'h01, $urandom);
         4: doAccess("rnd_adc_rd", 0, 6'h03, $urandom);
         5: doAccess("rnd_rd", 0, ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h04, $urandom);
         6: doAccess("rnd_irq_w1c", 1, 6'h04, $urandom);
         7: adcPulse(DW'($urandom));
         8: drain($urandom_range(1, 5));
         default: begin
            case ($urandom_range(0, 3))
               0: doAccess("rnd_unmapped", $urandom_range(0, 1) == 1, 6'($urandom_range(5, 63)), $urandom);
               1: doAccess("rnd_status_wr", 1, 6'h01, $urandom);
               2: doAccess("rnd_adc_wr", 1, 6'h03, $urandom);
               default: doAccess("rnd_dac_rd", 0, 6'h02, $urandom);
            endcase
         end
      endcase
      checkIrq("rnd_irq");
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] expRd;
      logic        err;
      bit          expErr;
      int          waits;

      // Reset state and first STATUS read
      doReset();
      #1;
      checkOutput("rst_pready", 32'(PREADY), 32'd0);
      checkOutput("rst_prdata", PRDATA, 32'd0);
      checkOutput("rst_pslverr", 32'(PSLVERR), 32'd0);
      checkOutput("rst_dac_valid", 32'(DAC_VALID), 32'd0);
      checkOutput("rst_irq", 32'(IRQ), 32'd0);
      applyStimulus(0, 6'h01, 32'd0, 1'b0, '0, rd, err, waits);
      checkOutput("first_status_waits", waits, 32'd1);
      checkOutput("first_status_prdata", rd, 32'h0000_0001);
      checkOutput("first_status_pslverr", 32'(err), 32'd0);

      // Fill the FIFO past full, then drain it
      doAccess("ctrl_dac_en", 1, 6'h00, 32'h1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 6'h02, 32'h123, 1'b0, '0, rd, err, waits);
         modelAccess(1, 6'h02, 32'h123, expRd, expErr);
         checkOutput("dac_wr_pslverr", 32'(err), (i == 8) ? 32'd1 : 32'd0);
      end
      applyStimulus(0, 6'h01, 32'd0, 1'b0, '0, rd, err, waits);
      checkOutput("status_full", rd, 32'h0000_0802);
      drain(9);

      // ADC double capture, overrun and interrupt
      doAccess("irq_clr_all", 1, 6'h04, 32'h3);
      doAccess("ctrl_adc_irq", 1, 6'h00, 32'h6);
      adcPulse(12'h0AB);
      adcPulse(12'h0CD);
      doAccess("status_ovr", 0, 6'h01, 32'd0);
      checkIrq("irq_after_adc");
      checkOutput("irq_after_adc_high", 32'(IRQ), 32'd1);
      doAccess("adc_rd_cd", 0, 6'h03, 32'd0);
      doAccess("status_ovr_cleared", 0, 6'h01, 32'd0);
      doAccess("irq_w1c_adc", 1, 6'h04, 32'h1);
      checkIrq("irq_after_w1c");
      checkOutput("irq_after_w1c_low", 32'(IRQ), 32'd0);

      // ADC strobe on the completing edge of an ADC_RD read
      adcPulse(12'h044);
      applyStimulus(0, 6'h03, 32'd0, 1'b1, 12'h055, rd, err, waits);
      checkOutput("adc_race_prdata", rd, 32'h0000_0044);
      modelAccess(0, 6'h03, 32'd0, expRd, expErr);
      modelAdc(12'h055);
      applyStimulus(0, 6'h01, 32'd0, 1'b0, '0, rd, err, waits);
      checkOutput("adc_race_status_bits", {28'd0, rd[3:2], 2'b00}, 32'h4);
      doAccess("adc_race_readback", 0, 6'h03, 32'd0);

      // Error responses leave state alone
      doAccess("unmapped_rd", 0, 6'h07, 32'd0);
      doAccess("unmapped_wr", 1, 6'h07, 32'hFFFF_FFFF);
      doAccess("status_wr", 1, 6'h01, 32'hFFFF_FFFF);
      doAccess("dac_rd", 0, 6'h02, 32'd0);
      doAccess("ctrl_after_err", 0, 6'h00, 32'd0);
      doAccess("status_after_err", 0, 6'h01, 32'd0);

      // Reset in the middle of a DAC_WR wait state
      doAccess("pre_fill", 1, 6'h02, 32'h321);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h02; PWDATA = 32'h5A5;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      checkOutput("wait_pready_low", 32'(PREADY), 32'd0);
      PRESET = 1'b1;
      #1;
      checkOutput("abort_pready", 32'(PREADY), 32'd0);
      checkOutput("abort_dac_valid", 32'(DAC_VALID), 32'd0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      resetModel();
      doAccess("status_after_abort", 0, 6'h01, 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 200; n++) begin
         randomOp();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
